// File: rtl/camera_tx_pkg.sv
// Shared types and constants for the camera sensor emulator.
// Holds the FSM state enum, pattern codes and Bayer colours.
package camera_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FRONT,
    S_LINE,
    S_HBLANK,
    S_BACK,
    S_VBLANK
  } state_t;

  localparam logic [1:0] PAT_HRAMP = 2'd0;
  localparam logic [1:0] PAT_VRAMP = 2'd1;
  localparam logic [1:0] PAT_BAYER = 2'd2;
  localparam logic [1:0] PAT_FCNT  = 2'd3;

  localparam logic [11:0] BAYER_R = 12'hF00;
  localparam logic [11:0] BAYER_G = 12'h0F0;
  localparam logic [11:0] BAYER_B = 12'h00F;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Combinational test-pattern pixel from (x, y, pattern, frame count).
// Ports: i_x/i_y position, i_pat code, i_fcnt frame count, o_pix value.
module camera_pattern_gen
  import camera_tx_pkg::*;
(
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  input  logic [1:0]  i_pat,
  input  logic [11:0] i_fcnt,
  output logic [11:0] o_pix
);

  logic [11:0] w_bayer;

  // Even/even is red, odd/odd is blue, the two mixed sites are green.
  always_comb begin
    w_bayer = BAYER_G;
    if (!i_y[0] && !i_x[0])
      w_bayer = BAYER_R;
    else if (i_y[0] && i_x[0])
      w_bayer = BAYER_B;
  end

  always_comb begin
    o_pix = '0;
    unique case (i_pat)
      PAT_HRAMP: o_pix = i_x;
      PAT_VRAMP: o_pix = i_y;
      PAT_BAYER: o_pix = w_bayer;
      PAT_FCNT:  o_pix = i_fcnt;
      default:   o_pix = '0;
    endcase
  end

endmodule

// File: rtl/camera_sensor_tx.sv
// Raw-Bayer sensor emulator driving a D/FVAL/LVAL parallel interface.
// Ports: clk, reset_n, enable, pattern_sel in; cam_d/fval/lval, frame_done, frame_count out.
module camera_sensor_tx
  import camera_tx_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 160,
  parameter int FV_TO_LV = 4,
  parameter int LV_TO_FV = 4,
  parameter int V_BLANK  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [11:0] cam_d,
  output logic        cam_fval,
  output logic        cam_lval,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  localparam int XYW = $clog2(max2(H_ACTIVE, V_ACTIVE) + 1);
  localparam int BW  = $clog2(max2(max2(H_BLANK, V_BLANK),
                                   max2(FV_TO_LV, LV_TO_FV)) + 1);

  localparam logic [XYW-1:0] X_LAST = XYW'(H_ACTIVE - 1);
  localparam logic [XYW-1:0] Y_LAST = XYW'(V_ACTIVE - 1);
  localparam logic [BW-1:0]  F_LAST = BW'(FV_TO_LV - 1);
  localparam logic [BW-1:0]  H_LAST = BW'(H_BLANK - 1);
  localparam logic [BW-1:0]  B_LAST = BW'(LV_TO_FV - 1);
  localparam logic [BW-1:0]  V_LAST = BW'(V_BLANK - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [XYW-1:0]   r_x;
  logic [XYW-1:0]   r_y;
  logic [XYW-1:0]   w_x_nxt;
  logic [XYW-1:0]   w_y_nxt;
  logic [BW-1:0]    r_bcnt;
  logic [BW-1:0]    w_bcnt_nxt;
  logic             w_latch;
  logic [1:0]       r_pat;
  logic [11:0]      w_pix;
  logic             w_vb_first;
  logic [11:0]      r_d;
  logic             r_fval;
  logic             r_lval;
  logic             r_done;
  logic [15:0]      r_frame_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_bcnt_nxt  = r_bcnt;
    w_latch     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state_nxt = S_FRONT;
          w_bcnt_nxt  = '0;
          w_latch     = 1'b1;
        end
      end
      S_FRONT: begin
        if (r_bcnt == F_LAST) begin
          w_state_nxt = S_LINE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      S_LINE: begin
        if (r_x == X_LAST) begin
          w_bcnt_nxt  = '0;
          w_state_nxt = (r_y == Y_LAST) ? S_BACK : S_HBLANK;
        end else begin
          w_x_nxt = r_x + 1'b1;
        end
      end
      S_HBLANK: begin
        if (r_bcnt == H_LAST) begin
          w_state_nxt = S_LINE;
          w_x_nxt     = '0;
          w_y_nxt     = r_y + 1'b1;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      S_BACK: begin
        if (r_bcnt == B_LAST) begin
          w_state_nxt = S_VBLANK;
          w_bcnt_nxt  = '0;
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      S_VBLANK: begin
        if (r_bcnt == V_LAST) begin
          w_bcnt_nxt = '0;
          if (enable) begin
            w_state_nxt = S_FRONT;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_bcnt_nxt = r_bcnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pattern is frozen at frame start so mid-frame changes wait a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_pat <= PAT_HRAMP;
    else if (w_latch)
      r_pat <= pattern_sel;
  end

  camera_pattern_gen u_pat (
    .i_x    (12'(r_x)),
    .i_y    (12'(r_y)),
    .i_pat  (r_pat),
    .i_fcnt (r_frame_count[11:0]),
    .o_pix  (w_pix)
  );

  assign w_vb_first = (r_state == S_VBLANK) && (r_bcnt == '0);

  // Outputs trail the state by one clock, all from the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_d           <= '0;
      r_fval        <= 1'b0;
      r_lval        <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_fval <= (r_state == S_FRONT) || (r_state == S_LINE) ||
                (r_state == S_HBLANK) || (r_state == S_BACK);
      r_lval <= (r_state == S_LINE);
      r_d    <= (r_state == S_LINE) ? w_pix : 12'h000;
      r_done <= w_vb_first;
      if (w_vb_first)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign cam_d       = r_d;
  assign cam_fval    = r_fval;
  assign cam_lval    = r_lval;
  assign frame_done  = r_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_camera_sensor_tx.sv
// Self-checking bench for camera_sensor_tx with a per-cycle scoreboard.
// Expected fval-window beats are queued per frame and popped by a monitor.
module tb_camera_sensor_tx;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 3;
  localparam int FL = 2;
  localparam int LF = 2;
  localparam int VB = 5;
  localparam int FRAME = 50;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [11:0] cam_d;
  logic        cam_fval;
  logic        cam_lval;
  logic        frame_done;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  camera_sensor_tx #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_BLANK  (HB),
    .FV_TO_LV (FL),
    .LV_TO_FV (LF),
    .V_BLANK  (VB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .cam_d       (cam_d),
    .cam_fval    (cam_fval),
    .cam_lval    (cam_lval),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic        lval;
    logic [11:0] d;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_pulses = 0;
  logic [15:0] m_fcnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] model_pix(input int pat, input int x,
                                            input int y,
                                            input logic [15:0] fc);
    logic [11:0] v;
    v = 12'h000;
    case (pat)
      0: v = x[11:0];
      1: v = y[11:0];
      2: begin
        if ((y % 2 == 0) && (x % 2 == 0)) v = 12'hF00;
        else if ((y % 2 == 1) && (x % 2 == 1)) v = 12'h00F;
        else v = 12'h0F0;
      end
      default: v = fc[11:0];
    endcase
    return v;
  endfunction

  task automatic push_frame(input int pat, input logic [15:0] fc);
    beat_t b;
    b.lval = 1'b0;
    b.d    = 12'h000;
    for (int i = 0; i < FL; i++) exp_q.push_back(b);
    for (int y = 0; y < VA; y++) begin
      for (int x = 0; x < HA; x++) begin
        b.lval = 1'b1;
        b.d    = model_pix(pat, x, y, fc);
        exp_q.push_back(b);
      end
      b.lval = 1'b0;
      b.d    = 12'h000;
      if (y < VA - 1)
        for (int i = 0; i < HB; i++) exp_q.push_back(b);
    end
    for (int i = 0; i < LF; i++) exp_q.push_back(b);
  endtask

  // Scoreboard: pops one beat per fval-high cycle, checks idle bus otherwise.
  always @(negedge clk) begin
    beat_t e;
    if (reset_n === 1'b1) begin
      n_checks++;
      if (cam_fval === 1'b1) begin
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected t=%0t lval=%b d=%h", $time,
                   cam_lval, cam_d);
        end else begin
          e = exp_q.pop_front();
          if ({cam_lval, cam_d} !== {e.lval, e.d})
            $display("FAIL sb_beat t=%0t got lval=%b d=%h want lval=%b d=%h",
                     $time, cam_lval, cam_d, e.lval, e.d);
          else
            n_pass++;
        end
      end else begin
        if (cam_fval !== 1'b0 || cam_lval !== 1'b0 || cam_d !== 12'h000)
          $display("FAIL sb_idle t=%0t got fval=%b lval=%b d=%h want 0/0/000",
                   $time, cam_fval, cam_lval, cam_d);
        else
          n_pass++;
      end
      if (frame_done === 1'b1) done_pulses++;
    end
  end

  task automatic wait_fval(input logic lvl, input string tag);
    int n;
    n = 0;
    while (cam_fval !== lvl && n < TMO) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= TMO) $display("FAIL %s timeout got fval=%b want %b", tag,
                           cam_fval, lvl);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset_n     = 1'b0;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (cam_d !== 12'h000) $display("FAIL rst_d got %h want 000", cam_d);
    else n_pass++;
    n_checks++;
    if (cam_fval !== 1'b0) $display("FAIL rst_fval got %b want 0", cam_fval);
    else n_pass++;
    n_checks++;
    if (cam_lval !== 1'b0) $display("FAIL rst_lval got %b want 0", cam_lval);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL rst_done got %b want 0", frame_done);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'h0) $display("FAIL rst_fcnt got %h want 0", frame_count);
    else n_pass++;
    m_fcnt = 16'h0;
    push_frame(0, m_fcnt);
    reset_n = 1'b1;
    enable  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cam_fval !== 1'b0) $display("FAIL start_lat1 got %b want 0", cam_fval);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cam_fval !== 1'b1) $display("FAIL start_lat2 got %b want 1", cam_fval);
    else n_pass++;
    enable = 1'b0;
  endtask

  task automatic test_hramp;
    int n;
    int lv_hi;
    int lv_rise;
    logic pl;
    n = 0; lv_hi = 0; lv_rise = 0; pl = 1'b0;
    while (cam_fval === 1'b1 && n < TMO) begin
      if (cam_lval === 1'b1) lv_hi++;
      if (cam_lval === 1'b1 && !pl) lv_rise++;
      pl = cam_lval;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (lv_hi != VA * HA) $display("FAIL hr_lval_cycles got %0d want %0d", lv_hi, VA * HA);
    else n_pass++;
    n_checks++;
    if (lv_rise != VA) $display("FAIL hr_lines got %0d want %0d", lv_rise, VA);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL hr_done got %b want 1", frame_done);
    else n_pass++;
    m_fcnt = m_fcnt + 16'd1;
    n_checks++;
    if (frame_count !== m_fcnt) $display("FAIL hr_fcnt got %h want %h", frame_count, m_fcnt);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL hr_sb_left got %0d want 0", exp_q.size());
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL hr_done_pulse got %b want 0", frame_done);
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_bayer;
    pattern_sel = 2'd2;
    enable      = 1'b1;
    push_frame(2, m_fcnt);
    @(negedge clk);
    enable = 1'b0;
    wait_fval(1'b1, "by_rise");
    wait_fval(1'b0, "by_fall");
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL by_done got %b want 1", frame_done);
    else n_pass++;
    m_fcnt = m_fcnt + 16'd1;
    n_checks++;
    if (frame_count !== m_fcnt) $display("FAIL by_fcnt got %h want %h", frame_count, m_fcnt);
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int rise[3];
    int d0;
    d0 = done_pulses;
    pattern_sel = 2'd1;
    enable      = 1'b1;
    push_frame(1, m_fcnt);
    for (int f = 0; f < 3; f++) begin
      wait_fval(1'b1, "b2b_rise");
      rise[f] = cyc;
      if (f == 0) begin
        @(negedge clk);
        pattern_sel = 2'd3;
        push_frame(3, 16'(m_fcnt + 16'd1));
        push_frame(3, 16'(m_fcnt + 16'd2));
      end
      if (f == 2) enable = 1'b0;
      wait_fval(1'b0, "b2b_fall");
      n_checks++;
      if (frame_done !== 1'b1) $display("FAIL b2b_done%0d got %b want 1", f, frame_done);
      else n_pass++;
      m_fcnt = m_fcnt + 16'd1;
      n_checks++;
      if (frame_count !== m_fcnt) $display("FAIL b2b_fcnt%0d got %h want %h", f, frame_count, m_fcnt);
      else n_pass++;
    end
    repeat (10) @(negedge clk);
    for (int f = 1; f < 3; f++) begin
      n_checks++;
      if (rise[f] - rise[f-1] != FRAME)
        $display("FAIL b2b_period%0d got %0d want %0d", f, rise[f] - rise[f-1], FRAME);
      else n_pass++;
    end
    n_checks++;
    if (done_pulses - d0 != 3) $display("FAIL b2b_pulses got %0d want 3", done_pulses - d0);
    else n_pass++;
  endtask

  task automatic test_mid_disable;
    int rises;
    int n;
    int hi;
    logic pl;
    rises = 0; n = 0; hi = 0; pl = 1'b0;
    pattern_sel = 2'd0;
    enable      = 1'b1;
    push_frame(0, m_fcnt);
    wait_fval(1'b1, "md_rise");
    while (rises < 2 && n < TMO) begin
      @(negedge clk);
      if (cam_lval === 1'b1 && !pl) rises++;
      pl = cam_lval;
      n++;
    end
    n_checks++;
    if (rises != 2) $display("FAIL md_line1 got %0d want 2", rises);
    else n_pass++;
    enable      = 1'b0;
    pattern_sel = 2'd1;
    wait_fval(1'b0, "md_fall");
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL md_done got %b want 1", frame_done);
    else n_pass++;
    m_fcnt = m_fcnt + 16'd1;
    n_checks++;
    if (frame_count !== m_fcnt) $display("FAIL md_fcnt got %h want %h", frame_count, m_fcnt);
    else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (cam_fval !== 1'b0) hi++;
    end
    n_checks++;
    if (hi != 0) $display("FAIL md_idle got %0d fval cycles want 0", hi);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    int hi;
    int d0;
    logic pl;
    n = 0; hi = 0; pl = 1'b0;
    pattern_sel = 2'd2;
    enable      = 1'b1;
    push_frame(2, m_fcnt);
    wait_fval(1'b1, "rm_rise");
    while (!(pl && cam_lval === 1'b0) && n < TMO) begin
      pl = cam_lval;
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (cam_fval !== 1'b1 || n >= TMO)
      $display("FAIL rm_hblank got fval=%b n=%0d want fval=1", cam_fval, n);
    else n_pass++;
    #1;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    n_checks++;
    if ({cam_fval, cam_lval, cam_d} !== 14'h0)
      $display("FAIL rm_drop got fval=%b lval=%b d=%h want 0/0/000", cam_fval, cam_lval, cam_d);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'h0) $display("FAIL rm_fcnt got %h want 0", frame_count);
    else n_pass++;
    exp_q.delete();
    m_fcnt = 16'h0;
    @(negedge clk);
    d0 = done_pulses;
    reset_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (cam_fval !== 1'b0) hi++;
    end
    n_checks++;
    if (hi != 0) $display("FAIL rm_idle got %0d fval cycles want 0", hi);
    else n_pass++;
    n_checks++;
    if (done_pulses != d0) $display("FAIL rm_no_done got %0d pulses want 0", done_pulses - d0);
    else n_pass++;
  endtask

  task automatic test_wrap;
    pattern_sel = 2'd0;
    enable      = 1'b1;
    push_frame(0, m_fcnt);
    @(negedge clk);
    enable = 1'b0;
    wait_fval(1'b1, "wr_rise");
    repeat (5) @(negedge clk);
    force dut.r_frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_count;
    @(negedge clk);
    n_checks++;
    if (frame_count !== 16'hFFFF) $display("FAIL wr_preload got %h want ffff", frame_count);
    else n_pass++;
    wait_fval(1'b0, "wr_fall");
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL wr_done got %b want 1", frame_done);
    else n_pass++;
    n_checks++;
    if (frame_count !== 16'h0000) $display("FAIL wr_fcnt got %h want 0000", frame_count);
    else n_pass++;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_hramp;
    test_bayer;
    test_back_to_back;
    test_mid_disable;
    test_reset_mid;
    test_wrap;
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_final got %0d beats left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/camera_sensor_tx.md
# camera_sensor_tx

Raw-Bayer camera sensor emulator: drives the same D/FVAL/LVAL parallel interface that the camera capture path consumes, so the capture and image-processing pipeline can be brought up and regressed without the D8M module attached. It sits at the FPGA top level and is muxed onto the camera conduit in place of the real sensor. Output timing is parameterised, and the pixel content is a selectable deterministic test pattern.

## Interface
- `H_ACTIVE`, 640, pixels per line (LVAL high clocks), ≥1
- `V_ACTIVE`, 480, lines per frame, ≥1
- `H_BLANK`, 160, clocks LVAL low between lines inside a frame, ≥1
- `FV_TO_LV`, 4, clocks FVAL high before first LVAL, ≥1
- `LV_TO_FV`, 4, clocks FVAL high after last LVAL, ≥1
- `V_BLANK`, 1000, clocks FVAL low between frames, ≥1
- `clk`  in  1  pixel clock; also forwarded externally as PIXCLK
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  start/continue frame generation
- `pattern_sel`  in  2  0 = horizontal ramp, 1 = vertical ramp, 2 = Bayer flat colour, 3 = frame counter
- `cam_d`  out  12  pixel data
- `cam_fval`  out  1  frame valid
- `cam_lval`  out  1  line valid
- `frame_done`  out  1  one-clock pulse at end of each frame
- `frame_count`  out  16  completed-frame counter

## Operation
- FSM states: IDLE, FRONT, LINE, HBLANK, BACK, VBLANK.
- IDLE: fval=0, lval=0. If `enable`=1, go to FRONT on the next clock.
- FRONT: lasts FV_TO_LV clocks with fval=1, lval=0, then goes to LINE with y=0.
- LINE: lasts H_ACTIVE clocks with fval=1, lval=1, and x runs 0..H_ACTIVE-1.
  - If y < V_ACTIVE-1: go to HBLANK.
  - Otherwise: go to BACK.
- HBLANK: lasts H_BLANK clocks with fval=1, lval=0. Then y++ and go to LINE.
- BACK: lasts LV_TO_FV clocks with fval=1, lval=0, then goes to VBLANK.
- VBLANK: lasts V_BLANK clocks with fval=0.
  - On the first VBLANK clock, `frame_done`=1 and `frame_count` increments, wrapping 0xFFFF→0.
  - On the last VBLANK clock, sample `enable`: 1 → FRONT, 0 → IDLE.
- `enable` is ignored inside a frame. Deasserting it mid-frame completes the current frame, including VBLANK.
- `pattern_sel` is latched on entry to FRONT and is held for the whole frame.
- Pixel value, valid only while lval=1 (cam_d=0 whenever lval=0):
  - pattern 0: x[11:0] (truncated, wraps every 4096)
  - pattern 1: y[11:0]
  - pattern 2: by {y[0],x[0]}: 00 → 12'hF00, 01 → 12'h0F0, 10 → 12'h0F0, 11 → 12'h00F
  - pattern 3: frame_count[11:0], constant across the frame
- Counter widths: x and y are $clog2(max param + 1). The blanking counter is wide enough for the largest of H_BLANK, FV_TO_LV, LV_TO_FV and V_BLANK.

## Timing
- All outputs are registered. cam_d, cam_fval and cam_lval change together on the same clock edge, with no skew between them.
- Reset: async assert forces IDLE. Reset values: cam_d=0, cam_fval=0, cam_lval=0, frame_done=0, frame_count=0, latched pattern=0.
- Reset asserted mid-frame drops fval and lval immediately. No frame_done is generated for the aborted frame.
- Start latency: with `enable` high in IDLE at edge N, cam_fval=1 after edge N+1.
- Frame period (back-to-back, `enable` held high): FV_TO_LV + V_ACTIVE·H_ACTIVE + (V_ACTIVE-1)·H_BLANK + LV_TO_FV + V_BLANK clocks.
- frame_done is asserted in the same cycle that cam_fval first reads 0. frame_count updates in that same cycle.
- Simultaneous events:
  - Parameters set to 1 give single-clock phases.
  - With V_ACTIVE=1, LINE goes directly to BACK, with no HBLANK.

## Structure
- Package `camera_tx_pkg` holds:
  - the state enum
  - pattern code constants (PAT_HRAMP, PAT_VRAMP, PAT_BAYER, PAT_FCNT)
  - the Bayer colour constants
- Sub-module `camera_pattern_gen`: combinational pixel value from (x, y, pattern, frame_count). The top-level module registers its output.
- Top-level module: FSM, x/y/blank counters, frame counter, and the output registers.

## Test plan
Use parameters H_ACTIVE=8, V_ACTIVE=4, H_BLANK=3, FV_TO_LV=2, LV_TO_FV=2, V_BLANK=5, which gives a 50-clock frame.
- **Reset state and start:** hold reset_n=0 → all outputs 0. Release with enable=1 → fval rises 2 clocks later, then lval high for 8 clocks, 4 times, with 3-clock gaps.
- **Horizontal ramp:** pattern 0 → each line reads cam_d 0..7 while lval=1, and 0 during every gap.
- **Bayer pattern:** pattern 2 → line 0 alternates F00/0F0, line 1 alternates 0F0/00F.
- **Back-to-back frames:** hold enable=1 → consecutive fval rising edges are exactly 50 clocks apart. frame_done pulses once per frame, and frame_count reads 1, 2, 3.
- **Mid-frame disable and pattern change:** drop enable and change pattern_sel during LINE of y=1 → the frame completes with the original pattern, then the FSM returns to IDLE and fval stays 0.
- **Reset mid-frame and counter wrap:** assert reset_n during HBLANK → fval/lval/cam_d go to 0 immediately and frame_count returns to 0. Force frame_count to 0xFFFF before a frame end → it reads 0 after that frame_done.
